// File: rtl/done_check_multi.sv
`default_nettype none
// ============================================================================
// Module   : done_check_multi
// Brief    : Watches N_CH packed channels until a sample with at most one
//            nonzero channel repeats STABLE times, then reports that channel.
// Revision : 1.0 - initial release
// ============================================================================
module done_check_multi #(
    parameter int N_CH   = 4,
    parameter int W      = 5,
    parameter int STABLE = 2,
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [N_CH*W-1:0] data,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  sel,
    output logic              all_zero
);

    localparam int c_CNT_W = $clog2(STABLE + 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_CNT = c_CNT_W'(STABLE);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_MONITOR = 2'd1;
    localparam logic [1:0] c_S_DONE    = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_cand;
    logic               r_cand_zero;
    logic               r_busy;
    logic               r_done;
    logic [SEL_W-1:0]   r_sel;
    logic               r_all_zero;

    logic [N_CH-1:0]    w_nz;
    logic               w_qual;
    logic               w_zero;
    logic [SEL_W-1:0]   w_cand;
    logic               w_match;
    logic [c_CNT_W-1:0] w_cnt_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_nz
        assign w_nz[i] = |data[i*W +: W];
    end

    // At most one bit set in w_nz means the sample qualifies.
    assign w_qual = ((w_nz & (w_nz - 1'b1)) == '0);
    assign w_zero = (w_nz == '0);

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_nz[i]) begin
                w_cand = SEL_W'(i);
            end
        end
    end

    // A zero counter makes increment and reload coincide, so the cleared
    // candidate after start needs no special "empty" marker.
    assign w_match    = (w_cand == r_cand) && (w_zero == r_cand_zero);
    assign w_cnt_next = w_match ? (r_cnt + 1'b1) : c_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_cand_zero <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sel       <= '0;
            r_all_zero  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state     <= c_S_MONITOR;
                        r_cnt       <= '0;
                        r_cand      <= '0;
                        r_cand_zero <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                c_S_MONITOR: begin
                    if (in_valid) begin
                        if (!w_qual) begin
                            r_cnt <= '0;
                        end else begin
                            r_cand      <= w_cand;
                            r_cand_zero <= w_zero;
                            r_cnt       <= w_cnt_next;
                            if (w_cnt_next == c_STABLE_CNT) begin
                                r_state    <= c_S_DONE;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_sel      <= w_cand;
                                r_all_zero <= w_zero;
                            end
                        end
                    end
                end
                c_S_DONE: begin
                    if (ack) begin
                        r_state    <= c_S_IDLE;
                        r_cnt      <= '0;
                        r_done     <= 1'b0;
                        r_sel      <= '0;
                        r_all_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_S_IDLE;
                    r_cnt      <= '0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_sel      <= '0;
                    r_all_zero <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sel      = r_sel;
    assign all_zero = r_all_zero;

endmodule
`default_nettype wire

// File: tb/tb_done_check_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_done_check_multi
// Brief    : Vector table, directed corner sequences and random traffic
//            checked against an abstract session model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_done_check_multi;

    localparam int N_CH   = 4;
    localparam int W      = 5;
    localparam int STABLE = 2;
    localparam int DW     = N_CH * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ack = 1'b0;
    logic          busy;
    logic          done;
    logic [1:0]    sel;
    logic          all_zero;

    int checks   = 0;
    int failures = 0;

    // Abstract model: session mode, length of the current run of identical
    // qualifying samples, and the identity of that run.
    int m_mode = 0;   // 0 idle, 1 monitoring, 2 reporting
    int m_run  = 0;
    int m_key  = -1;  // -1 none, -2 all-zero, else channel index
    int m_sel  = 0;
    int m_az   = 0;

    always #5 clk = ~clk;

    done_check_multi #(.N_CH(N_CH), .W(W), .STABLE(STABLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .data     (data),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .sel      (sel),
        .all_zero (all_zero)
    );

    typedef struct {
        logic          r, s, v;
        logic [DW-1:0] d;
        logic          a;
        logic          eb, ed;
        logic [1:0]    es;
        logic          ez;
    } vec_t;

    function automatic logic [DW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
        logic [4:0] a0, a1, a2, a3;
        a0 = c0[4:0]; a1 = c1[4:0]; a2 = c2[4:0]; a3 = c3[4:0];
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [DW-1:0] d,
                                input logic a, input logic eb, input logic ed, input logic [1:0] es,
                                input logic ez);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.d = d; t.a = a;
        t.eb = eb; t.ed = ed; t.es = es; t.ez = ez;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic v, input logic [DW-1:0] d,
                              input logic a);
        int nz, idx, k;
        logic [DW-1:0] dd;
        dd = d;
        if (r) begin
            m_mode = 0; m_run = 0; m_key = -1; m_sel = 0; m_az = 0;
        end else if (m_mode == 0) begin
            if (s) begin
                m_mode = 1; m_run = 0; m_key = -1;
            end
        end else if (m_mode == 1) begin
            if (v) begin
                nz = 0; idx = 0;
                for (int c = 0; c < N_CH; c++) begin
                    if (dd[c*W +: W] != 0) begin
                        nz++;
                        idx = c;
                    end
                end
                if (nz > 1) begin
                    m_run = 0;
                end else begin
                    k = (nz == 0) ? -2 : idx;
                    m_run = (k == m_key) ? m_run + 1 : 1;
                    m_key = k;
                    if (m_run == STABLE) begin
                        m_mode = 2;
                        m_sel  = (nz == 0) ? 0 : idx;
                        m_az   = (nz == 0) ? 1 : 0;
                    end
                end
            end
        end else begin
            if (a) begin
                m_mode = 0; m_sel = 0; m_az = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1ns later.
    task automatic cyc(input logic r, input logic s, input logic v, input logic [DW-1:0] d,
                       input logic a);
        rst = r; start = s; in_valid = v; data = d; ack = a;
        @(posedge clk);
        model_step(r, s, v, d, a);
        #1;
        chk("model_busy", {31'b0, busy}, (m_mode == 1) ? 32'd1 : 32'd0);
        chk("model_done", {31'b0, done}, (m_mode == 2) ? 32'd1 : 32'd0);
        chk("model_sel", {30'b0, sel}, 32'(m_sel));
        chk("model_all_zero", {31'b0, all_zero}, 32'(m_az));
    endtask

    vec_t tbl[15];
    logic [DW-1:0] q7, q3, q11, qz;
    logic [1:0] held_sel;
    logic held_az;

    initial begin
        q7  = pk(0, 0, 7, 0);
        q3  = pk(0, 3, 0, 0);
        q11 = pk(1, 1, 0, 0);
        qz  = '0;

        tbl[0]  = mk(1, 0, 0, qz,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, qz,  0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, q7,  0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, q7,  0, 0, 1, 2, 0);
        tbl[4]  = mk(0, 0, 0, qz,  1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, qz,  0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, q7,  0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, q3,  0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, q3,  0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 0, 0, qz,  1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, qz,  0, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, q11, 0, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, qz,  0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, qz,  0, 0, 1, 0, 1);
        tbl[14] = mk(0, 1, 0, qz,  1, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].a);
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
            chk($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, tbl[i].ed});
            chk($sformatf("vec%0d_sel", i), {30'b0, sel}, {30'b0, tbl[i].es});
            chk($sformatf("vec%0d_all_zero", i), {31'b0, all_zero}, {31'b0, tbl[i].ez});
        end

        // Idle gap between matching samples keeps the count; start mid-session ignored.
        cyc(0, 1, 0, qz, 0);
        cyc(0, 0, 1, q3, 0);
        cyc(0, 1, 0, qz, 0);
        chk("gap_no_done", {31'b0, done}, 32'd0);
        chk("gap_busy", {31'b0, busy}, 32'd1);
        cyc(0, 0, 1, q3, 0);
        chk("gap_done", {31'b0, done}, 32'd1);
        chk("gap_sel", {30'b0, sel}, 32'd1);
        cyc(0, 1, 1, q7, 1);
        chk("ackstart_done", {31'b0, done}, 32'd0);
        chk("ackstart_busy", {31'b0, busy}, 32'd0);

        // Reset mid-monitor discards the partial run.
        cyc(0, 1, 0, qz, 0);
        cyc(0, 0, 1, q7, 0);
        cyc(1, 1, 1, q7, 0);
        chk("rstmon_busy", {31'b0, busy}, 32'd0);
        cyc(0, 1, 0, qz, 0);
        cyc(0, 0, 1, q7, 0);
        chk("rstmon_no_done", {31'b0, done}, 32'd0);
        cyc(0, 0, 1, q7, 0);
        chk("rstmon_done", {31'b0, done}, 32'd1);
        chk("rstmon_sel", {30'b0, sel}, 32'd2);

        // Report stays frozen while traffic continues without ack.
        held_sel = sel;
        held_az  = all_zero;
        for (int i = 0; i < 10; i++) begin
            cyc(0, logic'($urandom_range(0, 1)), logic'(i % 2), DW'($urandom), 0);
            chk("hold_done", {31'b0, done}, 32'd1);
            chk("hold_sel", {30'b0, sel}, {30'b0, held_sel});
            chk("hold_all_zero", {31'b0, all_zero}, {31'b0, held_az});
        end

        // Reset mid-report wins over ack.
        cyc(1, 1, 1, q3, 1);
        chk("rstdone_done", {31'b0, done}, 32'd0);
        chk("rstdone_sel", {30'b0, sel}, 32'd0);

        // Random traffic, sparse channels so single-channel samples are common.
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] d;
            d = '0;
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 3) == 0) d[c*W +: W] = W'($urandom_range(1, 31));
            end
            cyc(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 2) != 0), d, logic'($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/done_check_multi.md
DONE_CHECK_MULTI -- requirements
Module: done_check_multi

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of monitored channels (legal range 2..16).
REQ-002 Parameter W, default 5, SHALL set the width of each channel value (1..16).
REQ-003 Parameter STABLE, default 2, SHALL set the consecutive qualifying samples required before done (1..255).
REQ-004 SEL_W SHALL be a derived localparam equal to max(1, ceil(log2(N_CH))).
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 start  input  1  begins a monitoring session.
REQ-008 in_valid  input  1  the data bus holds a sample this cycle.
REQ-009 data  input  N_CH*W  packed channel values; channel i occupies bits [i*W +: W].
REQ-010 ack  input  1  consumer acknowledges a reported result.
REQ-011 busy  output  1  high while in MONITOR.
REQ-012 done  output  1  high while in DONE.
REQ-013 sel  output  SEL_W  index of the single nonzero channel, valid while done=1.
REQ-014 all_zero  output  1  high with done when every channel was zero.

Function
REQ-015 A channel SHALL be nonzero when any of its W bits is 1; nz_cnt SHALL be the number of nonzero channels in a sample.
REQ-016 A sample SHALL qualify when nz_cnt <= 1; its candidate index SHALL be the nonzero channel's index, or 0 when nz_cnt = 0.
REQ-017 The FSM SHALL have exactly three states: IDLE, MONITOR and DONE.
REQ-018 IDLE: start=1 SHALL move to MONITOR and clear the stability counter and the stored candidate; in_valid and ack SHALL be ignored.
REQ-019 MONITOR, in_valid=0: all state SHALL hold.
REQ-020 MONITOR, in_valid=1 with a non-qualifying sample: the counter SHALL clear to 0.
REQ-021 MONITOR, in_valid=1 with a qualifying sample: the counter SHALL increment if the candidate and zero-status match the stored ones, else load 1; candidate and zero-status SHALL then be stored.
REQ-022 When the counter's next value equals STABLE, the FSM SHALL enter DONE on that same edge, so done rises the cycle after the qualifying sample (latency 1).
REQ-023 On entry to DONE, sel and all_zero SHALL be registered from that sample and held constant throughout DONE.
REQ-024 The counter SHALL be ceil(log2(STABLE+1)) bits wide and SHALL never exceed STABLE.
REQ-025 DONE: ack=1 SHALL return to IDLE on the next edge and clear done, sel and all_zero; in_valid and start SHALL be ignored.
REQ-026 start in MONITOR SHALL be ignored; the session SHALL NOT restart.
REQ-027 ack and start together in DONE SHALL go to IDLE; start SHALL be dropped.
REQ-028 Outside DONE, sel SHALL be 0 and all_zero SHALL be 0.
REQ-029 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 SHALL, on the next edge, force IDLE, clear the counter and stored candidate, and drive busy=0, done=0, sel=0, all_zero=0.
REQ-031 rst SHALL take priority over start, in_valid and ack in every state, including mid-MONITOR and mid-DONE.

Verification
(N_CH=4, W=5, STABLE=2 throughout.)
REQ-032 Reset then start; two in_valid samples {0,0,7,0} -> done=1 one cycle after the second sample, sel=2, all_zero=0, busy=0.
REQ-033 In MONITOR, samples {0,0,7,0}, {0,3,0,0}, {0,3,0,0} -> no done after the second sample (candidate changed); done=1 with sel=1 after the third.
REQ-034 In MONITOR, samples {1,1,0,0}, {0,0,0,0}, {0,0,0,0} -> counter cleared by the first; done=1, sel=0, all_zero=1 after the third.
REQ-035 Qualifying sample, one cycle with in_valid=0, then the same qualifying sample -> done still rises (idle cycles hold the count); ack with start high -> IDLE next cycle, done=0, busy=0.
REQ-036 rst asserted one cycle after the first qualifying sample, then start and one qualifying sample -> no done; a second qualifying sample is required.
REQ-037 In DONE with ack=0, data and in_valid toggled for 10 cycles -> done, sel and all_zero unchanged.
